// File: rtl/gcd_job_arbiter.sv
// Round-robin arbiter sharing one GCD engine between NUM_REQ requesters.
// Optional watchdog abort is built when GCD_ARB_TIMEOUT_EN is defined.
module gcd_job_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic                   CLKEN,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [3*NUM_REQ-1:0]   REQ_OPCODE,
    input  logic [NUM_REQ-1:0]     REQ_CT,
    input  logic [TIMEOUT_W-1:0]   TIMEOUT_CYC,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [NUM_REQ-1:0]     DONE_VLD,
    output logic                   DONE_ERR,
    output logic [SEL_W-1:0]       GCD_SEL,
    output logic                   GCD_START,
    output logic [2:0]             GCD_OPCODE,
    output logic                   GCD_CONSTANT_TIME,
    input  logic                   GCD_DONE,
    output logic                   BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [2:0]       opcode_q, opcode_d;
    logic             ct_q, ct_d;
    logic             err_q, err_d;
    logic             done_r_q, done_r_d;

    logic             pick_vld;
    logic [SEL_W-1:0] pick_idx;
    logic             done_rise;
    logic             wd_expire;

    assign done_rise = GCD_DONE & ~done_r_q;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!pick_vld && REQ[j]) begin
                pick_vld = 1'b1;
                pick_idx = SEL_W'(j);
            end
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_ISSUE) begin
            wd_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
        end
    end

    assign wd_expire = (state_q == S_WAIT) && (TIMEOUT_CYC != '0)
                       && (wd_cnt_q == TIMEOUT_CYC - TIMEOUT_W'(1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wd_cnt_q <= '0;
        end else if (CLKEN) begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign wd_expire      = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            opcode_q <= '0;
            ct_q     <= 1'b0;
            err_q    <= 1'b0;
            done_r_q <= 1'b0;
        end else if (CLKEN) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            opcode_q <= opcode_d;
            ct_q     <= ct_d;
            err_q    <= err_d;
            done_r_q <= done_r_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        opcode_d = opcode_q;
        ct_d     = ct_q;
        err_d    = err_q;
        done_r_d = GCD_DONE;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    idx_d    = pick_idx;
                    opcode_d = REQ_OPCODE[3*int'(pick_idx) +: 3];
                    ct_d     = REQ_CT[pick_idx];
                    err_d    = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real completion wins over a watchdog expiry on the same cycle.
                if (done_rise) begin
                    err_d   = 1'b0;
                    state_d = S_RETIRE;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_RETIRE;
                end
            end
            S_RETIRE: begin
                ptr_d   = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + SEL_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        GRANT             = '0;
        DONE_VLD          = '0;
        DONE_ERR          = 1'b0;
        GCD_START         = 1'b0;
        BUSY              = (state_q != S_IDLE);
        GCD_SEL           = idx_q;
        GCD_OPCODE        = opcode_q;
        GCD_CONSTANT_TIME = ct_q;
        if (state_q != S_IDLE) begin
            GRANT[idx_q] = 1'b1;
        end
        if (state_q == S_ISSUE) begin
            GCD_START = 1'b1;
        end
        if (state_q == S_RETIRE) begin
            DONE_VLD[idx_q] = 1'b1;
            DONE_ERR        = err_q;
        end
    end

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Scoreboard bench for gcd_job_arbiter: random request rounds against a
// rotating-priority reference model, with a reactive GCD engine model.
module tb_gcd_job_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           RESETn;
    logic           CLKEN;
    logic [N-1:0]   REQ;
    logic [3*N-1:0] REQ_OPCODE;
    logic [N-1:0]   REQ_CT;
    logic [15:0]    TIMEOUT_CYC;
    logic           GCD_DONE = 1'b0;
    logic [N-1:0]   GRANT;
    logic [N-1:0]   DONE_VLD;
    logic           DONE_ERR;
    logic [1:0]     GCD_SEL;
    logic           GCD_START;
    logic [2:0]     GCD_OPCODE;
    logic           GCD_CONSTANT_TIME;
    logic           BUSY;

    gcd_job_arbiter #(.NUM_REQ(N), .SEL_W(2), .TIMEOUT_W(16)) dut (
        .CLK(clk), .RESETn(RESETn), .CLKEN(CLKEN), .REQ(REQ),
        .REQ_OPCODE(REQ_OPCODE), .REQ_CT(REQ_CT), .TIMEOUT_CYC(TIMEOUT_CYC),
        .GRANT(GRANT), .DONE_VLD(DONE_VLD), .DONE_ERR(DONE_ERR),
        .GCD_SEL(GCD_SEL), .GCD_START(GCD_START), .GCD_OPCODE(GCD_OPCODE),
        .GCD_CONSTANT_TIME(GCD_CONSTANT_TIME), .GCD_DONE(GCD_DONE), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int opc;
        int ct;
        int err;
        int lat;
    } job_t;

    int   checks = 0;
    int   failures = 0;
    job_t start_q[$];
    job_t done_q[$];
    int   ptr_m = 0;
    logic en_prev = 1'b0;
    int   ecnt = 0;
    int   start_ecnt = 0;
    int   stuck_done = 0;
    int   eng_silent = 0;
    int   eng_st = 0;
    int   eng_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tracks whether the last rising edge actually advanced the design.
    always @(posedge clk) begin
        en_prev <= RESETn && CLKEN;
        if (RESETn && CLKEN) ecnt <= ecnt + 1;
    end

    // Monitor: pops expectations whenever the DUT issues or retires a job.
    always @(negedge clk) begin : mon
        job_t e;
        if (RESETn) begin
            chk("grant_onehot0", longint'($onehot0(GRANT)), 1);
            if (en_prev && GCD_START) begin
                if (start_q.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    e = start_q.pop_front();
                    chk("start_grant", GRANT, 1 << e.idx);
                    chk("start_sel", GCD_SEL, e.idx);
                    chk("start_opcode", GCD_OPCODE, e.opc);
                    chk("start_ct", GCD_CONSTANT_TIME, e.ct);
                    chk("start_busy", BUSY, 1);
                    start_ecnt = ecnt;
                end
            end
            if (en_prev && DONE_VLD != '0) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", DONE_VLD, 0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_vld", DONE_VLD, 1 << e.idx);
                    chk("done_err", DONE_ERR, e.err);
                    chk("done_sel_stable", GCD_SEL, e.idx);
                    chk("done_opcode_stable", GCD_OPCODE, e.opc);
                    if (e.lat >= 0) chk("done_latency_cycles", ecnt - start_ecnt, e.lat);
                end
            end
        end
    end

    // Engine model: after a start, hold level, drop done, then raise it fresh.
    always @(negedge clk) begin
        if (!RESETn) begin
            eng_st   = 0;
            GCD_DONE = 1'b0;
        end else if (en_prev) begin
            case (eng_st)
                0: begin
                    GCD_DONE = (stuck_done != 0);
                    if (GCD_START && eng_silent == 0) begin
                        eng_cnt = $urandom_range(1, 8);
                        eng_st  = 1;
                    end
                end
                1: begin
                    chk("no_early_done", DONE_VLD, 0);
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        GCD_DONE = 1'b0;
                        eng_st   = 2;
                    end
                end
                2: begin
                    chk("no_early_done", DONE_VLD, 0);
                    GCD_DONE = 1'b1;
                    eng_st   = 3;
                end
                default: begin
                    chk("done_edge_to_vld", longint'(DONE_VLD != '0), 1);
                    GCD_DONE = (stuck_done != 0);
                    eng_st   = 0;
                end
            endcase
        end
    end

    task automatic wait_jobs(input int expected, input bit hold, input bit rand_clken,
                             output int got);
        got = 0;
        for (int cyc = 0; cyc < 100 * expected && got < expected; cyc++) begin
            @(negedge clk);
            if (en_prev && DONE_VLD != '0) begin
                got++;
                if (!hold) REQ = REQ & ~DONE_VLD;
                else if (got == expected) REQ = '0;
            end
            CLKEN = rand_clken ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    // Reference model: rotating priority starting just after the last served requester.
    task automatic run_round(input logic [N-1:0] set, input bit hold, input int njobs,
                             input bit rand_clken, input int err, input int lat);
        logic [N-1:0] pend;
        int opc[N];
        int ct[N];
        int expected;
        int idx;
        int got;
        pend = set;
        for (int i = 0; i < N; i++) begin
            opc[i] = $urandom_range(0, 7);
            ct[i]  = $urandom_range(0, 1);
            REQ_OPCODE[3*i +: 3] = 3'(opc[i]);
            REQ_CT[i] = ct[i][0];
        end
        expected = hold ? njobs : $countones(set);
        for (int k = 0; k < expected; k++) begin
            idx = -1;
            for (int s = 0; s < N; s++)
                if (idx < 0 && pend[(ptr_m + s) % N]) idx = (ptr_m + s) % N;
            start_q.push_back('{idx, opc[idx], ct[idx], err, lat});
            done_q.push_back('{idx, opc[idx], ct[idx], err, lat});
            if (!hold) pend[idx] = 1'b0;
            ptr_m = (idx + 1) % N;
        end
        REQ = set;
        wait_jobs(expected, hold, rand_clken, got);
        chk("round_complete", got, expected);
        REQ   = '0;
        CLKEN = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #600000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int got;
        bit st;
        logic [N-1:0] set;
        RESETn = 1'b0; CLKEN = 1'b1; REQ = '0; REQ_OPCODE = '0; REQ_CT = '0;
        TIMEOUT_CYC = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", GRANT, 0);
        chk("rst_done_vld", DONE_VLD, 0);
        chk("rst_done_err", DONE_ERR, 0);
        chk("rst_sel", GCD_SEL, 0);
        chk("rst_start", GCD_START, 0);
        chk("rst_opcode", GCD_OPCODE, 0);
        chk("rst_ct", GCD_CONSTANT_TIME, 0);
        chk("rst_busy", BUSY, 0);
        RESETn = 1'b1;
        repeat (2) @(negedge clk);

        // All four held for eight jobs: strict rotation 0,1,2,3,0,1,2,3.
        run_round(4'b1111, 1'b1, 8, 1'b0, 0, -1);

        // Single request on requester 2; owner drops REQ and changes opcode mid-job.
        REQ_OPCODE = '0; REQ_OPCODE[8:6] = 3'd5; REQ_CT = '0;
        start_q.push_back('{2, 5, 0, 0, -1});
        done_q.push_back('{2, 5, 0, 0, -1});
        ptr_m = 3;
        REQ = 4'b0100;
        @(negedge clk);
        chk("t1_start_after_1", GCD_START, 1);
        chk("t1_grant", GRANT, 4'b0100);
        REQ_OPCODE[8:6] = 3'd1;
        REQ = '0;
        wait_jobs(1, 1'b1, 1'b0, got);
        chk("t1_complete", got, 1);
        repeat (3) @(negedge clk);

        // Same job with CLKEN toggling.
        run_round(4'b0100, 1'b0, 1, 1'b1, 0, -1);

        // Done stuck high before the request: only a fresh edge completes.
        stuck_done = 1;
        repeat (4) @(negedge clk);
        run_round(4'b0001, 1'b0, 1, 1'b0, 0, -1);
        stuck_done = 0;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 24; r++) begin
            set = 4'($urandom_range(1, 15));
            if (r % 5 == 4) run_round(set, 1'b1, $urandom_range(2, 6), r[0], 0, -1);
            else            run_round(set, 1'b0, 0, r[0], 0, -1);
        end

        // Async reset while waiting on a silent engine.
        run_round(4'b0010, 1'b0, 1, 1'b0, 0, -1);
        eng_silent = 1;
        REQ_OPCODE = 12'hFFF; REQ_CT = '1;
        start_q.push_back('{3, 7, 1, 0, -1});
        REQ = 4'b1000;
        st = 1'b0;
        for (int c = 0; c < 20 && !st; c++) begin
            @(negedge clk);
            if (en_prev && GCD_START) st = 1'b1;
        end
        chk("t6_started", st, 1);
        repeat (3) @(negedge clk);
        #2 RESETn = 1'b0;
        #1;
        chk("t6_rst_grant", GRANT, 0);
        chk("t6_rst_busy", BUSY, 0);
        chk("t6_rst_sel", GCD_SEL, 0);
        chk("t6_rst_opcode", GCD_OPCODE, 0);
        chk("t6_rst_ct", GCD_CONSTANT_TIME, 0);
        chk("t6_rst_start", GCD_START, 0);
        chk("t6_rst_done", DONE_VLD, 0);
        REQ = '0;
        start_q.delete();
        done_q.delete();
        ptr_m = 0;
        eng_silent = 0;
        @(negedge clk);
        RESETn = 1'b1;
        @(negedge clk);
        run_round(4'b0110, 1'b0, 0, 1'b0, 0, -1);
        run_round(4'b0001, 1'b0, 0, 1'b0, 0, -1);

`ifdef GCD_ARB_TIMEOUT_EN
        // Watchdog abort 21 cycles after start, then normal service and a stray edge.
        TIMEOUT_CYC = 16'd20;
        eng_silent = 1;
        run_round(4'b0100, 1'b0, 1, 1'b0, 1, 21);
        eng_silent = 0;
        run_round(4'b1000, 1'b0, 1, 1'b0, 0, -1);
        stuck_done = 1;
        repeat (4) @(negedge clk);
        chk("t5_stray_ignored", BUSY, 0);
        stuck_done = 0;
        repeat (3) @(negedge clk);
        run_round(4'b1011, 1'b0, 0, 1'b1, 0, -1);
`endif

        for (int r = 0; r < 6; r++) begin
            set = 4'($urandom_range(1, 15));
            run_round(set, 1'b0, 0, 1'b1, 0, -1);
        end

        chk("queues_drained", start_q.size() + done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
